// File: rtl/regfile_rn_pkg.sv
// Shared defaults and read-result encoding for the renamed register file.
// Pure definitions: no latency, no backpressure.
package regfile_rn_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_REG_W   = 5;
    localparam int DEF_ROB_W   = 4;
    localparam int DEF_REG_NUM = 2 ** DEF_REG_W;

    localparam logic TYPE_VAL = 1'b0;
    localparam logic TYPE_TAG = 1'b1;

endpackage

// File: rtl/regfile_rn_rdport.sv
// One operand read port: returns register value, same-cycle commit bypass, or ROB tag.
// Combinational, zero latency; never stalls.
module regfile_rn_rdport
    import regfile_rn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int ROB_W  = DEF_ROB_W,
    parameter int NUM_CP = 1
) (
    input  logic                     query_i,
    input  logic [REG_W-1:0]         pos_i,
    input  logic [DATA_W-1:0]        reg_val_i,
    input  logic [ROB_W-1:0]         reg_qi_i,
    input  logic                     reg_busy_i,
    input  logic [NUM_CP-1:0]        unlock_i,
    input  logic [NUM_CP*ROB_W-1:0]  unlock_robpos_i,
    input  logic [NUM_CP*DATA_W-1:0] unlock_val_i,
    output logic                     flag_o,
    output logic                     type_o,
    output logic [DATA_W-1:0]        val_o
);

    logic              hit;
    logic [DATA_W-1:0] hit_val;

    // Ascending scan: the youngest matching commit is the last one to assign.
    always_comb begin
        hit     = 1'b0;
        hit_val = '0;
        for (int k = 0; k < NUM_CP; k++) begin
            if (unlock_i[k] && unlock_robpos_i[k*ROB_W +: ROB_W] == reg_qi_i) begin
                hit     = 1'b1;
                hit_val = unlock_val_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        flag_o = query_i;
        type_o = TYPE_VAL;
        val_o  = '0;
        if (query_i && pos_i != '0) begin
            if (!reg_busy_i) begin
                val_o = reg_val_i;
            end else if (hit) begin
                val_o = hit_val;
            end else begin
                type_o = TYPE_TAG;
                val_o  = DATA_W'(reg_qi_i);
            end
        end
    end

endmodule

// File: rtl/regfile_rn.sv
// Architectural register file with rename tags, multi-port reads/commits and flush.
// Reads combinational (same-cycle commit bypass); lock/commit take effect next cycle; ready=0 freezes state.
module regfile_rn
    import regfile_rn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int ROB_W  = DEF_ROB_W,
    parameter int NUM_RP = 2,
    parameter int NUM_CP = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ready,
    input  logic                     flush,
    input  logic [NUM_RP-1:0]        rd_query,
    input  logic [NUM_RP*REG_W-1:0]  rd_pos,
    output logic [NUM_RP-1:0]        rd_flag,
    output logic [NUM_RP-1:0]        rd_type,
    output logic [NUM_RP*DATA_W-1:0] rd_val,
    input  logic                     lock,
    input  logic [REG_W-1:0]         lock_rd,
    input  logic [ROB_W-1:0]         lock_robpos,
    input  logic [NUM_CP-1:0]        unlock,
    input  logic [NUM_CP*REG_W-1:0]  unlock_rd,
    input  logic [NUM_CP*ROB_W-1:0]  unlock_robpos,
    input  logic [NUM_CP*DATA_W-1:0] unlock_val
);

    localparam int REG_NUM = 2 ** REG_W;

    logic [DATA_W-1:0] val_q  [REG_NUM];
    logic [DATA_W-1:0] val_d  [REG_NUM];
    logic [ROB_W-1:0]  qi_q   [REG_NUM];
    logic [ROB_W-1:0]  qi_d   [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    always_comb begin
        val_d  = val_q;
        qi_d   = qi_q;
        busy_d = busy_q;
        if (ready) begin
            // Commits always write the value; busy clears only on a live tag match.
            for (int k = 0; k < NUM_CP; k++) begin
                if (unlock[k] && unlock_rd[k*REG_W +: REG_W] != '0) begin
                    val_d[unlock_rd[k*REG_W +: REG_W]] = unlock_val[k*DATA_W +: DATA_W];
                    if (busy_q[unlock_rd[k*REG_W +: REG_W]] &&
                        qi_q[unlock_rd[k*REG_W +: REG_W]] == unlock_robpos[k*ROB_W +: ROB_W]) begin
                        busy_d[unlock_rd[k*REG_W +: REG_W]] = 1'b0;
                    end
                end
            end
            if (flush) begin
                for (int r = 0; r < REG_NUM; r++) begin
                    qi_d[r]   = '0;
                    busy_d[r] = 1'b0;
                end
            end else if (lock && lock_rd != '0) begin
                qi_d[lock_rd]   = lock_robpos;
                busy_d[lock_rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            val_q  <= '{default: '0};
            qi_q   <= '{default: '0};
            busy_q <= '0;
        end else begin
            val_q  <= val_d;
            qi_q   <= qi_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_RP; p++) begin : g_rp
        regfile_rn_rdport #(
            .DATA_W (DATA_W),
            .REG_W  (REG_W),
            .ROB_W  (ROB_W),
            .NUM_CP (NUM_CP)
        ) u_rdport (
            .query_i         (rd_query[p]),
            .pos_i           (rd_pos[p*REG_W +: REG_W]),
            .reg_val_i       (val_q[rd_pos[p*REG_W +: REG_W]]),
            .reg_qi_i        (qi_q[rd_pos[p*REG_W +: REG_W]]),
            .reg_busy_i      (busy_q[rd_pos[p*REG_W +: REG_W]]),
            .unlock_i        (unlock),
            .unlock_robpos_i (unlock_robpos),
            .unlock_val_i    (unlock_val),
            .flag_o          (rd_flag[p]),
            .type_o          (rd_type[p]),
            .val_o           (rd_val[p*DATA_W +: DATA_W])
        );
    end

endmodule
